// File: rtl/st_pkg.sv
// Shared definitions for the store alignment unit: func3 codes, FSM state encoding
// and base byte-strobe patterns.
package st_pkg;

    localparam logic [2:0] ST_SB = 3'b000;
    localparam logic [2:0] ST_SH = 3'b001;
    localparam logic [2:0] ST_SW = 3'b010;

    localparam logic [3:0] STRB_B = 4'b0001;
    localparam logic [3:0] STRB_H = 4'b0011;
    localparam logic [3:0] STRB_W = 4'b1111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2
    } st_state_e;

endpackage

// File: rtl/st_lane_gen.sv
// Combinational lane generator: masks store data to the access size and shifts data
// and strobes into a 64-bit / 8-lane window spanning two words.
module st_lane_gen
    import st_pkg::*;
(
    input  logic [2:0]  func3_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] data_i,
    output logic [63:0] wide_o,
    output logic [7:0]  smask_o,
    output logic        split_o,
    output logic        illegal_o
);

    logic [3:0]  m;
    logic [31:0] masked;

    always_comb begin
        m         = 4'b0000;
        masked    = 32'h0;
        illegal_o = 1'b0;
        case (func3_i)
            ST_SB: begin
                m      = STRB_B;
                masked = {24'h0, data_i[7:0]};
            end
            ST_SH: begin
                m      = STRB_H;
                masked = {16'h0, data_i[15:0]};
            end
            ST_SW: begin
                m      = STRB_W;
                masked = data_i;
            end
            default: illegal_o = 1'b1;
        endcase
    end

    assign wide_o  = {32'h0, masked} << {off_i, 3'b000};
    assign smask_o = {4'b0000, m} << off_i;
    assign split_o = |smask_o[7:4];

endmodule

// File: rtl/st_align_unit.sv
// Store alignment unit: accepts a store, issues one or two word-aligned write beats.
// Build option: MISALIGN_TRAP_EN rejects word-crossing stores with st_err.
//
// state | meaning
// IDLE  | ready for a request; st_done / st_err pulses appear here
// BEAT0 | first (or only) beat at the base word address
// BEAT1 | second beat at base+4 for word-crossing stores
module st_align_unit
    import st_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_func3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_data,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [3:0]        mem_wstrb,
    output logic              st_done,
    output logic              st_err
);

    st_state_e         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d, hi_wdata_q, hi_wdata_d;
    logic [3:0]        wstrb_q, wstrb_d, hi_wstrb_q, hi_wstrb_d;
    logic              split_q, split_d;
    logic              done_q, done_d, err_q, err_d;

    logic [63:0] wide;
    logic [7:0]  smask;
    logic        split, illegal, reject;

    st_lane_gen u_lane_gen (
        .func3_i   (req_func3),
        .off_i     (req_addr[1:0]),
        .data_i    (req_data),
        .wide_o    (wide),
        .smask_o   (smask),
        .split_o   (split),
        .illegal_o (illegal)
    );

`ifdef MISALIGN_TRAP_EN
    assign reject = illegal | split;
`else
    assign reject = illegal;
`endif

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        hi_wdata_d = hi_wdata_q;
        hi_wstrb_d = hi_wstrb_q;
        split_d    = split_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (reject) begin
                        err_d = 1'b1;
                    end else begin
                        state_d    = BEAT0;
                        addr_d     = {req_addr[ADDR_W-1:2], 2'b00};
                        wdata_d    = wide[31:0];
                        wstrb_d    = smask[3:0];
                        hi_wdata_d = wide[63:32];
                        hi_wstrb_d = smask[7:4];
                        split_d    = split;
                    end
                end
            end
            BEAT0: begin
                if (mem_ready) begin
                    if (split_q) begin
                        state_d = BEAT1;
                        addr_d  = addr_q + ADDR_W'(4);
                        wdata_d = hi_wdata_q;
                        wstrb_d = hi_wstrb_q;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            BEAT1: begin
                if (mem_ready) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            hi_wdata_q <= '0;
            hi_wstrb_q <= '0;
            split_q    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            hi_wdata_q <= hi_wdata_d;
            hi_wstrb_q <= hi_wstrb_d;
            split_q    <= split_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // mem_valid decodes the state register so it falls with the async reset
    assign req_ready = (state_q == IDLE);
    assign mem_valid = (state_q != IDLE);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wstrb = wstrb_q;
    assign st_done   = done_q;
    assign st_err    = err_q;

endmodule

// File: tb/tb_st_align_unit.sv
// Directed, table-driven bench for st_align_unit (default build and MISALIGN_TRAP_EN).
module tb_st_align_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_func3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_data = 32'h0;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        st_done;
    logic        st_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    st_align_unit #(.XLEN(32), .ADDR_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_func3 (req_func3),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .st_done   (st_done),
        .st_err    (st_err)
    );

    typedef struct {
        logic [2:0]  func3;
        logic [31:0] addr;
        logic [31:0] data;
        int          delay;
        logic        err;
        int          nbeats;
        logic [31:0] a0;
        logic [31:0] d0;
        logic [3:0]  s0;
        logic [31:0] a1;
        logic [31:0] d1;
        logic [3:0]  s1;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_beat(input string tag, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] s);
        chk({tag, " mem_valid"}, {31'h0, mem_valid}, 32'h1);
        chk({tag, " mem_addr"}, mem_addr, a);
        chk({tag, " mem_wdata"}, mem_wdata, d);
        chk({tag, " mem_wstrb"}, {28'h0, mem_wstrb}, {28'h0, s});
        chk({tag, " req_ready"}, {31'h0, req_ready}, 32'h0);
        chk({tag, " st_done"}, {31'h0, st_done}, 32'h0);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        string tag;
        logic        err;
        int          nb;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        tag = $sformatf("v%0d", idx);
        err = v.err;
        nb  = v.nbeats;
`ifdef MISALIGN_TRAP_EN
        if (nb == 2) err = 1'b1;
`endif
        chk({tag, " req_ready idle"}, {31'h0, req_ready}, 32'h1);
        req_valid = 1'b1;
        req_func3 = v.func3;
        req_addr  = v.addr;
        req_data  = v.data;
        tick();
        req_valid = 1'b0;
        req_data  = 32'h5A5A5A5A;
        if (err) begin
            chk({tag, " st_err"}, {31'h0, st_err}, 32'h1);
            chk({tag, " err mem_valid"}, {31'h0, mem_valid}, 32'h0);
            chk({tag, " err st_done"}, {31'h0, st_done}, 32'h0);
            tick();
            chk({tag, " st_err clear"}, {31'h0, st_err}, 32'h0);
            chk({tag, " err mem_valid2"}, {31'h0, mem_valid}, 32'h0);
            return;
        end
        for (int b = 0; b < nb; b++) begin
            a = (b == 0) ? v.a0 : v.a1;
            d = (b == 0) ? v.d0 : v.d1;
            s = (b == 0) ? v.s0 : v.s1;
            for (int w = 0; w < v.delay; w++) begin
                check_beat($sformatf("%s b%0d wait%0d", tag, b, w), a, d, s);
                tick();
            end
            mem_ready = 1'b1;
            check_beat($sformatf("%s b%0d", tag, b), a, d, s);
            tick();
            mem_ready = 1'b0;
        end
        chk({tag, " st_done"}, {31'h0, st_done}, 32'h1);
        chk({tag, " st_err quiet"}, {31'h0, st_err}, 32'h0);
        chk({tag, " mem_valid after"}, {31'h0, mem_valid}, 32'h0);
        chk({tag, " req_ready after"}, {31'h0, req_ready}, 32'h1);
        tick();
        chk({tag, " st_done clear"}, {31'h0, st_done}, 32'h0);
    endtask

    initial begin
        vecs[0]  = '{3'b010, 32'h0000_0100, 32'hDEADBEEF, 0, 1'b0, 1, 32'h100,  32'hDEADBEEF, 4'b1111, 32'h0,    32'h0,        4'b0000};
        vecs[1]  = '{3'b000, 32'h0000_0203, 32'h123456A5, 0, 1'b0, 1, 32'h200,  32'hA5000000, 4'b1000, 32'h0,    32'h0,        4'b0000};
        vecs[2]  = '{3'b001, 32'h0000_0303, 32'h00001234, 0, 1'b0, 2, 32'h300,  32'h34000000, 4'b1000, 32'h304,  32'h00000012, 4'b0001};
        vecs[3]  = '{3'b010, 32'h0000_1001, 32'hDEADBEEF, 3, 1'b0, 2, 32'h1000, 32'hADBEEF00, 4'b1110, 32'h1004, 32'h000000DE, 4'b0001};
        vecs[4]  = '{3'b011, 32'h0000_0100, 32'hDEADBEEF, 0, 1'b1, 0, 32'h0,    32'h0,        4'b0000, 32'h0,    32'h0,        4'b0000};
        vecs[5]  = '{3'b001, 32'h0000_0402, 32'hABCD5678, 1, 1'b0, 1, 32'h400,  32'h56780000, 4'b1100, 32'h0,    32'h0,        4'b0000};
        vecs[6]  = '{3'b000, 32'h0000_0501, 32'hFFFFFF3C, 0, 1'b0, 1, 32'h500,  32'h00003C00, 4'b0010, 32'h0,    32'h0,        4'b0000};
        vecs[7]  = '{3'b010, 32'h0000_0603, 32'h11223344, 1, 1'b0, 2, 32'h600,  32'h44000000, 4'b1000, 32'h604,  32'h00112233, 4'b0111};
        vecs[8]  = '{3'b111, 32'h0000_0700, 32'h11111111, 0, 1'b1, 0, 32'h0,    32'h0,        4'b0000, 32'h0,    32'h0,        4'b0000};
        vecs[9]  = '{3'b001, 32'h0000_0700, 32'hFFFF8001, 2, 1'b0, 1, 32'h700,  32'h00008001, 4'b0011, 32'h0,    32'h0,        4'b0000};
        vecs[10] = '{3'b010, 32'h0000_0802, 32'hCAFEF00D, 0, 1'b0, 2, 32'h800,  32'hF00D0000, 4'b1100, 32'h804,  32'h0000CAFE, 4'b0011};
        vecs[11] = '{3'b001, 32'h0000_0901, 32'h0000BEEF, 0, 1'b0, 1, 32'h900,  32'h00BEEF00, 4'b0110, 32'h0,    32'h0,        4'b0000};

        #2;
        chk("reset mem_valid", {31'h0, mem_valid}, 32'h0);
        chk("reset mem_addr", mem_addr, 32'h0);
        chk("reset mem_wdata", mem_wdata, 32'h0);
        chk("reset mem_wstrb", {28'h0, mem_wstrb}, 32'h0);
        chk("reset st_done", {31'h0, st_done}, 32'h0);
        chk("reset st_err", {31'h0, st_err}, 32'h0);
        #10 rst_n = 1'b1;
        tick();
        chk("post-reset req_ready", {31'h0, req_ready}, 32'h1);

        for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

        // reset while a beat is pending in BEAT0
        req_valid = 1'b1; req_func3 = 3'b010; req_addr = 32'h40; req_data = 32'h0BADF00D;
        tick();
        req_valid = 1'b0;
        check_beat("rst0", 32'h40, 32'h0BADF00D, 4'b1111);
        #2 rst_n = 1'b0;
        #1;
        chk("rst0 mem_valid drop", {31'h0, mem_valid}, 32'h0);
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rst0 no st_done", {31'h0, st_done}, 32'h0);
            chk("rst0 req_ready", {31'h0, req_ready}, 32'h1);
            chk("rst0 mem_valid idle", {31'h0, mem_valid}, 32'h0);
        end

`ifndef MISALIGN_TRAP_EN
        // address wrap across the top of memory, then reset in BEAT1
        req_valid = 1'b1; req_func3 = 3'b010; req_addr = 32'hFFFFFFFE; req_data = 32'h01020304;
        tick();
        req_valid = 1'b0;
        mem_ready = 1'b1;
        check_beat("wrap b0", 32'hFFFFFFFC, 32'h03040000, 4'b1100);
        tick();
        mem_ready = 1'b0;
        check_beat("wrap b1", 32'h00000000, 32'h00000102, 4'b0011);
        #2 rst_n = 1'b0;
        #1;
        chk("wrap mem_valid drop", {31'h0, mem_valid}, 32'h0);
        chk("wrap st_done", {31'h0, st_done}, 32'h0);
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("wrap no st_done", {31'h0, st_done}, 32'h0);
            chk("wrap req_ready", {31'h0, req_ready}, 32'h1);
        end
`endif

        // back-to-back aligned stores: one store per two cycles with mem_ready held high
        mem_ready = 1'b1;
        req_valid = 1'b1; req_func3 = 3'b000; req_addr = 32'h10; req_data = 32'h000000AA;
        tick();
        chk("b2b first beat", {31'h0, mem_valid}, 32'h1);
        tick();
        chk("b2b ready again", {31'h0, req_ready}, 32'h1);
        chk("b2b done", {31'h0, st_done}, 32'h1);
        req_addr = 32'h14; req_data = 32'h000000BB;
        tick();
        req_valid = 1'b0;
        chk("b2b second addr", mem_addr, 32'h14);
        chk("b2b second wdata", mem_wdata, 32'h000000BB);
        tick();
        mem_ready = 1'b0;
        chk("b2b second done", {31'h0, st_done}, 32'h1);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

endmodule
